// File: rtl/accumulator_banks_pingpong_pkg.sv
// Shared types and the saturation helper for the
// ping-pong accumulator array.
package accumulator_pkg;

    typedef enum logic [1:0] {
        BW4,
        BW8,
        BW16,
        BW16_ALT
    } bitwidth_e;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

    localparam int SAT_IN_W  = 64;
    localparam int SAT_OUT_W = 16;

    // Clamp a sign-extended accumulator to the selected precision.
    function automatic logic signed [SAT_OUT_W-1:0] sat(
        input logic signed [SAT_IN_W-1:0] v,
        input bitwidth_e                  bw
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        unique case (bw)
            BW4: begin
                hi = 64'sd7;
                lo = -64'sd8;
            end
            BW8: begin
                hi = 64'sd127;
                lo = -64'sd128;
            end
            default: begin
                hi = 64'sd32767;
                lo = -64'sd32768;
            end
        endcase
        if (v > hi) begin
            return hi[SAT_OUT_W-1:0];
        end else if (v < lo) begin
            return lo[SAT_OUT_W-1:0];
        end else begin
            return v[SAT_OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/accumulator_banks_pingpong_if.sv
// Write ports, swap handshake and drain stream of
// the ping-pong accumulator array.
interface accumulator_banks_pingpong_if #(
    parameter int BANK_COUNT = 16,
    parameter int ENTRIES    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    localparam int BW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [1:0]                           bitwidth;
    logic [BANK_COUNT-1:0]                wr_en;
    logic [BANK_COUNT-1:0][EW-1:0]        wr_entry;
    logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] wr_data;
    logic [BANK_COUNT-1:0]                wr_overwrite;
    logic                                 transfer;
    logic                                 transfer_ready;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [OUT_WIDTH-1:0]                 out_data;
    logic [BW-1:0]                        out_bank;
    logic [EW-1:0]                        out_entry;
    logic                                 out_last;

    modport master (
        output bitwidth,
        output wr_en,
        output wr_entry,
        output wr_data,
        output wr_overwrite,
        output transfer,
        output out_ready,
        input  transfer_ready,
        input  out_valid,
        input  out_data,
        input  out_bank,
        input  out_entry,
        input  out_last
    );

    modport slave (
        input  bitwidth,
        input  wr_en,
        input  wr_entry,
        input  wr_data,
        input  wr_overwrite,
        input  transfer,
        input  out_ready,
        output transfer_ready,
        output out_valid,
        output out_data,
        output out_bank,
        output out_entry,
        output out_last
    );

endinterface

// File: rtl/accumulator_banks_pingpong_bank_pair.sv
// One bank's front/back accumulator buffers with a
// write-forwarding read port for the drain.
module accumulator_bank_pair #(
    parameter int ENTRIES    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int EW         = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        front_sel,
    input  logic                        wr_en,
    input  logic [EW-1:0]               wr_entry,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                        wr_overwrite,
    input  logic                        rd_sel,
    input  logic [EW-1:0]               rd_entry,
    input  logic                        clr_en,
    input  logic [EW-1:0]               clr_entry,
    output logic signed [ACC_WIDTH-1:0] rd_data
);

    logic signed [ACC_WIDTH-1:0] mem [2][ENTRIES];
    logic signed [ACC_WIDTH-1:0] wr_ext;
    logic signed [ACC_WIDTH-1:0] wr_val;

    assign wr_ext = ACC_WIDTH'(wr_data);
    assign wr_val = wr_overwrite ? wr_ext
                                 : mem[front_sel][wr_entry] + wr_ext;

    // Front accumulates/overwrites; back clears the accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    mem[s][i] <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                mem[front_sel][wr_entry] <= wr_val;
            end
            if (clr_en) begin
                mem[~front_sel][clr_entry] <= '0;
            end
        end
    end

    // Read the value the entry holds after this edge, so a
    // swap-cycle write is seen by the first drain beat.
    always_comb begin
        rd_data = mem[rd_sel][rd_entry];
        if (wr_en && (rd_sel == front_sel) && (wr_entry == rd_entry)) begin
            rd_data = wr_val;
        end
    end

endmodule

// File: rtl/accumulator_banks_pingpong.sv
// Ping-pong accumulator array: bank pairs, swap FSM,
// serial saturating clear-on-read drain.
module accumulator_banks_pingpong
    import accumulator_pkg::*;
#(
    parameter int BANK_COUNT = 16,
    parameter int ENTRIES    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    accumulator_banks_pingpong_if.slave bus
);

    localparam int BW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [BW-1:0] LAST_BANK  = BW'(BANK_COUNT - 1);
    localparam logic [EW-1:0] LAST_ENTRY = EW'(ENTRIES - 1);

    drain_state_e state_q, state_d;
    logic         front_sel_q, front_sel_d;
    bitwidth_e    drain_bw_q, drain_bw_d;
    logic [BW-1:0] ptr_bank_q, ptr_bank_d;
    logic [EW-1:0] ptr_entry_q, ptr_entry_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

    logic      swap;
    logic      accept;
    logic      load;
    logic      rd_sel;
    bitwidth_e load_bw;
    logic [BANK_COUNT-1:0]       clr_en;
    logic signed [ACC_WIDTH-1:0] rd_data [BANK_COUNT];
    logic signed [ACC_WIDTH-1:0] rd_pick;

    assign swap   = bus.transfer && (state_q == IDLE);
    assign accept = out_valid_q && bus.out_ready;
    // On a swap the outgoing buffer is still the front one.
    assign rd_sel = swap ? front_sel_q : ~front_sel_q;

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        assign clr_en[b] = accept && (ptr_bank_q == BW'(b));

        accumulator_bank_pair #(
            .ENTRIES    (ENTRIES),
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .EW         (EW)
        ) u_pair (
            .clk          (clk),
            .reset        (reset),
            .front_sel    (front_sel_q),
            .wr_en        (bus.wr_en[b]),
            .wr_entry     (bus.wr_entry[b]),
            .wr_data      (bus.wr_data[b]),
            .wr_overwrite (bus.wr_overwrite[b]),
            .rd_sel       (rd_sel),
            .rd_entry     (ptr_entry_d),
            .clr_en       (clr_en[b]),
            .clr_entry    (ptr_entry_q),
            .rd_data      (rd_data[b])
        );
    end

    // Swap/drain control and next drain pointer.
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        drain_bw_d  = drain_bw_q;
        ptr_bank_d  = ptr_bank_q;
        ptr_entry_d = ptr_entry_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load        = 1'b0;
        load_bw     = drain_bw_q;
        unique case (state_q)
            IDLE: begin
                if (swap) begin
                    state_d     = DRAIN;
                    front_sel_d = ~front_sel_q;
                    drain_bw_d  = bitwidth_e'(bus.bitwidth);
                    load_bw     = bitwidth_e'(bus.bitwidth);
                    ptr_bank_d  = '0;
                    ptr_entry_d = '0;
                    out_valid_d = 1'b1;
                    load        = 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        if (ptr_entry_q == LAST_ENTRY) begin
                            ptr_entry_d = '0;
                            ptr_bank_d  = ptr_bank_q + BW'(1);
                        end else begin
                            ptr_entry_d = ptr_entry_q + EW'(1);
                        end
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_last_d = (ptr_bank_d == LAST_BANK) &&
                         (ptr_entry_d == LAST_ENTRY);
        end
    end

    // Select the next beat and saturate it.
    always_comb begin
        rd_pick    = rd_data[ptr_bank_d];
        out_data_d = out_data_q;
        if (load) begin
            out_data_d = OUT_WIDTH'(sat(SAT_IN_W'(rd_pick), load_bw));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer select, latched precision, pointer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel_q <= 1'b0;
            drain_bw_q  <= BW4;
            ptr_bank_q  <= '0;
            ptr_entry_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            front_sel_q <= front_sel_d;
            drain_bw_q  <= drain_bw_d;
            ptr_bank_q  <= ptr_bank_d;
            ptr_entry_q <= ptr_entry_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.transfer_ready = (state_q == IDLE);
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_bank       = ptr_bank_q;
    assign bus.out_entry      = ptr_entry_q;
    assign bus.out_last       = out_last_q;

endmodule
